// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA horizontal/vertical timing generator with blanked, registered colour and syncs
//
// Ports:
//   i_pix_clk          pixel clock, all logic on its rising edge
//   i_reset            synchronous active-high reset
//   o_horz_coord       current x inside the visible line, 0 elsewhere
//   o_vert_coord       current y inside the visible frame, 0 elsewhere
//   o_in_active_area   current (h,v) is a visible pixel
//   o_line_start       one-cycle pulse at h == 0
//   o_frame_start      one-cycle pulse at h == 0, v == 0
//   i_red/green/blue   3-3-2 colour from the pixel source for the current coordinates
//   o_vga_red/green/blue  registered colour, forced to 0 outside the active area
//   o_vga_hsync/vsync  registered syncs, polarity set by *_ACTIVE_LOW
module vga_timing_gen #(
    parameter int HORZ_PIXEL_COUNT = 640,
    parameter int HORZ_FRONT_PORCH = 16,
    parameter int HORZ_SYNC_WIDTH  = 96,
    parameter int HORZ_BACK_PORCH  = 48,
    parameter int VERT_PIXEL_COUNT = 480,
    parameter int VERT_FRONT_PORCH = 10,
    parameter int VERT_SYNC_WIDTH  = 2,
    parameter int VERT_BACK_PORCH  = 33,
    parameter int HSYNC_ACTIVE_LOW = 1,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic        i_pix_clk,
    input  logic        i_reset,
    output logic [15:0] o_horz_coord,
    output logic [15:0] o_vert_coord,
    output logic        o_in_active_area,
    output logic        o_line_start,
    output logic        o_frame_start,
    input  logic [2:0]  i_red,
    input  logic [2:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic [2:0]  o_vga_red,
    output logic [2:0]  o_vga_green,
    output logic [1:0]  o_vga_blue,
    output logic        o_vga_hsync,
    output logic        o_vga_vsync
);

    localparam int HT = HORZ_PIXEL_COUNT + HORZ_FRONT_PORCH + HORZ_SYNC_WIDTH + HORZ_BACK_PORCH;
    localparam int VT = VERT_PIXEL_COUNT + VERT_FRONT_PORCH + VERT_SYNC_WIDTH + VERT_BACK_PORCH;

    localparam logic [15:0] H_LAST     = 16'(HT - 1);
    localparam logic [15:0] V_LAST     = 16'(VT - 1);
    localparam logic [15:0] H_VIS      = 16'(HORZ_PIXEL_COUNT);
    localparam logic [15:0] V_VIS      = 16'(VERT_PIXEL_COUNT);
    localparam logic [15:0] H_SYNC_BEG = 16'(HORZ_PIXEL_COUNT + HORZ_FRONT_PORCH);
    localparam logic [15:0] H_SYNC_END = 16'(HORZ_PIXEL_COUNT + HORZ_FRONT_PORCH + HORZ_SYNC_WIDTH);
    localparam logic [15:0] V_SYNC_BEG = 16'(VERT_PIXEL_COUNT + VERT_FRONT_PORCH);
    localparam logic [15:0] V_SYNC_END = 16'(VERT_PIXEL_COUNT + VERT_FRONT_PORCH + VERT_SYNC_WIDTH);

    // Pin level when the sync is NOT asserted; XOR with it yields the pin level.
    localparam logic HS_IDLE = (HSYNC_ACTIVE_LOW != 0);
    localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0);

    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        h_vis;
    logic        v_vis;
    logic        in_active;
    logic        hs_act;
    logic        vs_act;

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? 16'd0 : v_count + 16'd1;
        end else begin
            h_count <= h_count + 16'd1;
        end
    end

    assign h_vis     = (h_count < H_VIS);
    assign v_vis     = (v_count < V_VIS);
    assign in_active = h_vis && v_vis;
    // vsync spans whole lines, so it depends on v only.
    assign hs_act    = (h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END);
    assign vs_act    = (v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END);

    // Decoded outputs are held quiet while reset is asserted so the pixel
    // source never sees a stray start pulse from stale counter values.
    assign o_in_active_area = in_active && !i_reset;
    assign o_horz_coord     = (h_vis && !i_reset) ? h_count : 16'd0;
    assign o_vert_coord     = (v_vis && !i_reset) ? v_count : 16'd0;
    assign o_line_start     = (h_count == 16'd0) && !i_reset;
    assign o_frame_start    = (h_count == 16'd0) && (v_count == 16'd0) && !i_reset;

    // Colour and syncs for (h,v) leave together one cycle later, keeping them aligned.
    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            o_vga_red   <= '0;
            o_vga_green <= '0;
            o_vga_blue  <= '0;
            o_vga_hsync <= HS_IDLE;
            o_vga_vsync <= VS_IDLE;
        end else begin
            o_vga_red   <= in_active ? i_red   : 3'd0;
            o_vga_green <= in_active ? i_green : 3'd0;
            o_vga_blue  <= in_active ? i_blue  : 2'd0;
            o_vga_hsync <= hs_act ^ HS_IDLE;
            o_vga_vsync <= vs_act ^ VS_IDLE;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default 640x480 timing
    logic        a_rst;
    logic [15:0] a_hc, a_vc;
    logic        a_act, a_ls, a_fs;
    logic [2:0]  a_ri, a_gi;
    logic [1:0]  a_bi;
    logic [2:0]  a_r, a_g;
    logic [1:0]  a_b;
    logic        a_hs, a_vs;

    vga_timing_gen u_a (
        .i_pix_clk(clk), .i_reset(a_rst),
        .o_horz_coord(a_hc), .o_vert_coord(a_vc), .o_in_active_area(a_act),
        .o_line_start(a_ls), .o_frame_start(a_fs),
        .i_red(a_ri), .i_green(a_gi), .i_blue(a_bi),
        .o_vga_red(a_r), .o_vga_green(a_g), .o_vga_blue(a_b),
        .o_vga_hsync(a_hs), .o_vga_vsync(a_vs)
    );

    // Instances B (active-low syncs) and C (active-high syncs): small 14x7 timing
    logic        s_rst;
    logic [2:0]  s_ri, s_gi;
    logic [1:0]  s_bi;
    logic [15:0] b_hc, b_vc, c_hc, c_vc;
    logic        b_act, b_ls, b_fs, c_act, c_ls, c_fs;
    logic [2:0]  b_r, b_g, c_r, c_g;
    logic [1:0]  b_b, c_b;
    logic        b_hs, b_vs, c_hs, c_vs;

    vga_timing_gen #(
        .HORZ_PIXEL_COUNT(8), .HORZ_FRONT_PORCH(2), .HORZ_SYNC_WIDTH(2), .HORZ_BACK_PORCH(2),
        .VERT_PIXEL_COUNT(4), .VERT_FRONT_PORCH(1), .VERT_SYNC_WIDTH(1), .VERT_BACK_PORCH(1),
        .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1)
    ) u_b (
        .i_pix_clk(clk), .i_reset(s_rst),
        .o_horz_coord(b_hc), .o_vert_coord(b_vc), .o_in_active_area(b_act),
        .o_line_start(b_ls), .o_frame_start(b_fs),
        .i_red(s_ri), .i_green(s_gi), .i_blue(s_bi),
        .o_vga_red(b_r), .o_vga_green(b_g), .o_vga_blue(b_b),
        .o_vga_hsync(b_hs), .o_vga_vsync(b_vs)
    );

    vga_timing_gen #(
        .HORZ_PIXEL_COUNT(8), .HORZ_FRONT_PORCH(2), .HORZ_SYNC_WIDTH(2), .HORZ_BACK_PORCH(2),
        .VERT_PIXEL_COUNT(4), .VERT_FRONT_PORCH(1), .VERT_SYNC_WIDTH(1), .VERT_BACK_PORCH(1),
        .HSYNC_ACTIVE_LOW(0), .VSYNC_ACTIVE_LOW(0)
    ) u_c (
        .i_pix_clk(clk), .i_reset(s_rst),
        .o_horz_coord(c_hc), .o_vert_coord(c_vc), .o_in_active_area(c_act),
        .o_line_start(c_ls), .o_frame_start(c_fs),
        .i_red(s_ri), .i_green(s_gi), .i_blue(s_bi),
        .o_vga_red(c_r), .o_vga_green(c_g), .o_vga_blue(c_b),
        .o_vga_hsync(c_hs), .o_vga_vsync(c_vs)
    );

    int hs_lows, ls_count, b_vs_lows, c_vs_highs, fs_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles of the small instances starting from (0,0); k counts cycles since release.
    task automatic run_small(input int n);
        int h, v, ph, pv;
        logic vis_prev, hs_prev, vs_prev;
        b_vs_lows  = 0;
        c_vs_highs = 0;
        fs_count   = 0;
        for (int k = 0; k < n; k++) begin
            h = k % 14;
            v = (k / 14) % 7;
            chk("b_hcoord", b_hc, (h < 8) ? h : 0);
            chk("b_vcoord", b_vc, (v < 4) ? v : 0);
            chk("b_active", b_act, (h < 8 && v < 4) ? 1 : 0);
            chk("b_line_start", b_ls, (h == 0) ? 1 : 0);
            chk("b_frame_start", b_fs, (k % 98 == 0) ? 1 : 0);
            chk("c_frame_start", c_fs, (k % 98 == 0) ? 1 : 0);
            if (b_fs) fs_count++;
            if (k > 0) begin
                ph = (k - 1) % 14;
                pv = ((k - 1) / 14) % 7;
                vis_prev = (ph < 8 && pv < 4);
                hs_prev  = (ph >= 10 && ph < 12);
                vs_prev  = (pv == 5);
                chk("b_hsync", b_hs, hs_prev ? 0 : 1);
                chk("b_vsync", b_vs, vs_prev ? 0 : 1);
                chk("c_hsync", c_hs, hs_prev ? 1 : 0);
                chk("c_vsync", c_vs, vs_prev ? 1 : 0);
                chk("b_red", b_r, vis_prev ? 7 : 0);
                chk("c_blue", c_b, vis_prev ? 3 : 0);
                if (k <= 98 && !b_vs) b_vs_lows++;
                if (k <= 98 && c_vs) c_vs_highs++;
            end
            tick();
        end
    endtask

    initial begin
        int h, v, ph;
        a_rst = 1'b1; s_rst = 1'b1;
        a_ri = 3'd0; a_gi = 3'd0; a_bi = 2'd0;
        s_ri = 3'd7; s_gi = 3'd7; s_bi = 2'd3;
        repeat (3) tick();

        // Held in reset
        chk("rst_hsync", a_hs, 1);
        chk("rst_vsync", a_vs, 1);
        chk("rst_red", a_r, 0);
        chk("rst_blue", a_b, 0);
        chk("rst_active", a_act, 0);
        chk("rst_line_start", a_ls, 0);
        chk("rst_frame_start", a_fs, 0);
        chk("rst_c_hsync", c_hs, 0);

        // Release A: two lines plus one cycle of default timing
        a_rst = 1'b0;
        #1;
        hs_lows  = 0;
        ls_count = 0;
        for (int k = 0; k <= 1600; k++) begin
            h = k % 800;
            v = k / 800;
            chk("a_hcoord", a_hc, (h < 640) ? h : 0);
            chk("a_vcoord", a_vc, v);
            chk("a_active", a_act, (h < 640) ? 1 : 0);
            chk("a_line_start", a_ls, (h == 0) ? 1 : 0);
            chk("a_frame_start", a_fs, (k == 0) ? 1 : 0);
            if (a_ls) ls_count++;
            if (k > 0) begin
                ph = (k - 1) % 800;
                chk("a_hsync", a_hs, (ph >= 656 && ph < 752) ? 0 : 1);
                chk("a_vsync", a_vs, 1);
                if (k <= 800) begin
                    chk("a_blank_red", a_r, (ph < 640) ? 7 : 0);
                    chk("a_blank_green", a_g, (ph < 640) ? 7 : 0);
                    chk("a_blank_blue", a_b, (ph < 640) ? 3 : 0);
                    if (!a_hs) hs_lows++;
                end else begin
                    chk("a_feed_red", a_r, (ph < 640) ? (ph % 8) : 0);
                end
            end
            if (k < 799) begin
                a_ri = 3'd7; a_gi = 3'd7; a_bi = 2'd3;
            end else begin
                a_ri = a_hc[2:0]; a_gi = 3'd0; a_bi = 2'd0;
            end
            tick();
        end
        chk("a_hsync_width", hs_lows, 96);
        chk("a_line_count", ls_count, 3);

        // Small instances: two full frames
        s_rst = 1'b0;
        #1;
        run_small(197);
        chk("b_vsync_width", b_vs_lows, 14);
        chk("c_vsync_width", c_vs_highs, 14);
        chk("b_frame_count", fs_count, 3);

        // Mid-frame reset at (h=3, v=2)
        repeat (30) tick();
        chk("mid_pre_hcoord", b_hc, 3);
        chk("mid_pre_vcoord", b_vc, 2);
        s_rst = 1'b1;
        tick();
        chk("mid_rst_frame_start", b_fs, 0);
        chk("mid_rst_active", b_act, 0);
        chk("mid_rst_b_hsync", b_hs, 1);
        chk("mid_rst_b_vsync", b_vs, 1);
        chk("mid_rst_c_hsync", c_hs, 0);
        chk("mid_rst_c_vsync", c_vs, 0);
        s_rst = 1'b0;
        #1;
        chk("mid_rel_b_hsync", b_hs, 1);
        chk("mid_rel_c_vsync", c_vs, 0);
        run_small(99);
        chk("mid_vsync_width", b_vs_lows, 14);
        chk("mid_frame_count", fs_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates VGA horizontal/vertical timing for one pixel clock domain. Drives pixel coordinates and the active-area flag to the pattern/pixel source, takes its 3-3-2 colour back, blanks it outside the active area, and registers colour and syncs together for the VGA connector. It sits between the pixel source (e.g. `test_pattern`) and the DAC/resistor ladder pins.

## Interface
Parameters:
- HORZ_PIXEL_COUNT, 640, visible pixels per line
- HORZ_FRONT_PORCH, 16, pixels
- HORZ_SYNC_WIDTH, 96, pixels
- HORZ_BACK_PORCH, 48, pixels
- VERT_PIXEL_COUNT, 480, visible lines per frame
- VERT_FRONT_PORCH, 10, lines
- VERT_SYNC_WIDTH, 2, lines
- VERT_BACK_PORCH, 33, lines
- HSYNC_ACTIVE_LOW, 1, 1 = hsync pin low during sync
- VSYNC_ACTIVE_LOW, 1, 1 = vsync pin low during sync

Ports:
- i_pix_clk  in  1  pixel clock; the single clock, all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- o_horz_coord  out  16  current x; 0 outside the visible line
- o_vert_coord  out  16  current y; 0 outside the visible frame
- o_in_active_area  out  1  current (h,v) is visible
- o_line_start  out  1  one-cycle pulse at h==0
- o_frame_start  out  1  one-cycle pulse at h==0, v==0
- i_red  in  3  pixel colour for current coordinates
- i_green  in  3
- i_blue  in  2
- o_vga_red  out  3  registered, blanked colour
- o_vga_green  out  3
- o_vga_blue  out  2
- o_vga_hsync  out  1  registered hsync, polarity per parameter
- o_vga_vsync  out  1  registered vsync, polarity per parameter

## Operation
- HT = sum of HORZ_*; VT = sum of VERT_* (defaults 800, 525). Both must be ≤ 65535.
- h counter 0..HT-1, increments every cycle; at HT-1 wraps to 0 and v increments. v counter 0..VT-1; at h==HT-1 and v==VT-1 both wrap to 0.
- Line layout: visible [0, HPC), front porch, sync [HPC+HFP, HPC+HFP+HSW), back porch. Vertical identical in lines.
- Decode from current counter registers (combinational, same cycle):
  - o_in_active_area = (h < HPC) && (v < VPC).
  - o_horz_coord = h if h < HPC else 0; o_vert_coord = v if v < VPC else 0 (each axis independent).
  - hs_act = h in sync window; vs_act = v in sync window (vsync asserted for whole lines, including porch pixels).
  - o_line_start = (h == 0); o_frame_start = (h == 0 && v == 0).
- Output register stage (every cycle): o_vga_colour <= in_active ? i_colour : 0; o_vga_hsync <= hs_act XOR HSYNC_ACTIVE_LOW; o_vga_vsync <= vs_act XOR VSYNC_ACTIVE_LOW.
- Reset (i_reset high on a rising edge): h=0, v=0, o_vga_* colour 0, syncs at inactive level (1 for active-low). While i_reset is high, o_in_active_area, o_line_start, o_frame_start are forced 0 and coords read 0. Reset mid-frame restarts at (0,0); the first cycle after release has o_frame_start=1.
- No state machine beyond the counters; no error/overflow states exist.

## Timing
- Coordinates, active flag and pulses: 0-cycle decode of counters.
- Pixel source is combinational; colour for (h,v) appears on o_vga_* one cycle later, in the same cycle as the sync level for (h,v). Sync and colour therefore stay aligned.
- Line period HT cycles, frame period HT*VT cycles (420000 at defaults).
- hsync pulse exactly HSW cycles per line; vsync pulse exactly VSW*HT cycles per frame.

## Test plan
- Reset: hold i_reset 3 cycles -> o_vga_hsync=1, o_vga_vsync=1, colour 0, o_in_active_area=0; first cycle after release o_frame_start=1, coords (0,0).
- Horizontal timing (defaults): count cycles from release -> o_in_active_area falls after h=639; o_vga_hsync low for cycles where registered h = 656..751 (96 cycles); o_line_start every 800 cycles.
- Vertical timing with small params (H 8/2/2/2, V 4/1/1/1, HT=14, VT=7) -> o_vga_vsync low for 14 cycles starting at registered v=5, h=0; o_frame_start every 98 cycles.
- Blanking: drive i_red=7, i_green=7, i_blue=3 constantly -> o_vga_* = 7/7/3 only one cycle after o_in_active_area=1, else 0; coords read 0 in porch/sync regions.
- Coordinate feed-through: i_red = o_horz_coord[2:0] -> o_vga_red in cycle n+1 equals h[2:0] of cycle n.
- Mid-frame reset at (h=300,v=200), 1 cycle -> next cycle coords (0,0), o_frame_start=1, syncs inactive; polarity params set to 0 -> sync pins high only during sync windows.
